// File: rtl/display_sequencer.sv
// display_sequencer: row-scan time base and overlay sequencing for the 8x8 LED matrix.
// Chooses between the live playfield and the score/dead/win pictures and freezes the
// game while a picture is shown. All outputs are registered.
module display_sequencer #(
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned SCORE_FRAMES = 250,
  parameter int unsigned BLINK_FRAMES = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       score_evt,
  input  logic       dead_evt,
  input  logic       win_evt,
  input  logic       restart,
  output logic       scan_tick,
  output logic       frame_tick,
  output logic       score_flag,
  output logic       dead_flag,
  output logic       win_flag,
  output logic       play_en,
  output logic       game_freeze,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    StPlay  = 2'd0,
    StScore = 2'd1,
    StDead  = 2'd2,
    StWin   = 2'd3
  } state_e;

  // Counters only ever hold 0..N-1, so $clog2(N) bits suffice (min 1 bit).
  localparam int unsigned DivW = $clog2(SCAN_DIV);
  localparam int unsigned FrmW = (SCORE_FRAMES > 1) ? $clog2(SCORE_FRAMES) : 1;
  localparam int unsigned BlkW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);
  localparam logic [FrmW-1:0] FrmLast = FrmW'(SCORE_FRAMES - 1);
  localparam logic [BlkW-1:0] BlkLast = BlkW'(BLINK_FRAMES - 1);

  logic [DivW-1:0] div_cnt_q, div_cnt_d;
  logic [2:0]      row_cnt_q, row_cnt_d;

  state_e          state_q;
  logic            score_p_q, dead_p_q, win_p_q;
  logic [FrmW-1:0] frm_cnt_q;
  logic [BlkW-1:0] blink_cnt_q;
  logic            blink_off_q;

  // An event arriving in the same cycle as frame_tick still counts for that boundary.
  logic score_any, dead_any, win_any;
  assign score_any = score_p_q | score_evt;
  assign dead_any  = dead_p_q | dead_evt;
  assign win_any   = win_p_q | win_evt;

  // Next values of the prescaler and row counter.
  always_comb begin
    div_cnt_d = (div_cnt_q == DivLast) ? '0 : div_cnt_q + 1'b1;
    row_cnt_d = scan_tick ? row_cnt_q + 3'd1 : row_cnt_q;
  end

  // Time base: ticks are registered from next-state so they line up with div_cnt==last.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt_q  <= '0;
      row_cnt_q  <= 3'd0;
      scan_tick  <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      div_cnt_q  <= div_cnt_d;
      row_cnt_q  <= row_cnt_d;
      scan_tick  <= (div_cnt_d == DivLast);
      frame_tick <= (div_cnt_d == DivLast) && (row_cnt_d == 3'd7);
    end
  end

  // Overlay FSM with event latching, hold/blink counters and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StPlay;
      score_p_q   <= 1'b0;
      dead_p_q    <= 1'b0;
      win_p_q     <= 1'b0;
      frm_cnt_q   <= '0;
      blink_cnt_q <= '0;
      blink_off_q <= 1'b0;
      score_flag  <= 1'b0;
      dead_flag   <= 1'b0;
      win_flag    <= 1'b0;
      play_en     <= 1'b1;
      game_freeze <= 1'b0;
      state       <= 2'd0;
    end else begin
      if (restart) begin
        state_q     <= StPlay;
        score_p_q   <= 1'b0;
        dead_p_q    <= 1'b0;
        win_p_q     <= 1'b0;
        frm_cnt_q   <= '0;
        blink_cnt_q <= '0;
        blink_off_q <= 1'b0;
      end else begin
        unique case (state_q)
          StPlay, StScore: begin
            if (frame_tick) begin
              score_p_q <= 1'b0;
              dead_p_q  <= 1'b0;
              win_p_q   <= 1'b0;
              if (win_any) begin
                state_q <= StWin;
              end else if (dead_any) begin
                state_q     <= StDead;
                blink_cnt_q <= '0;
                blink_off_q <= 1'b0;
              end else if (score_any) begin
                state_q   <= StScore;
                frm_cnt_q <= '0;
              end else if (state_q == StScore) begin
                if (frm_cnt_q == FrmLast) begin
                  state_q   <= StPlay;
                  frm_cnt_q <= '0;
                end else begin
                  frm_cnt_q <= frm_cnt_q + 1'b1;
                end
              end
            end else begin
              score_p_q <= score_any;
              dead_p_q  <= dead_any;
              win_p_q   <= win_any;
            end
          end
          StDead: begin
            if (frame_tick) begin
              if (blink_cnt_q == BlkLast) begin
                blink_cnt_q <= '0;
                blink_off_q <= ~blink_off_q;
              end else begin
                blink_cnt_q <= blink_cnt_q + 1'b1;
              end
            end
          end
          StWin: ;
        endcase
      end

      // Outputs follow the state register by one clock.
      score_flag  <= (state_q == StScore);
      dead_flag   <= (state_q == StDead) && !blink_off_q;
      win_flag    <= (state_q == StWin);
      play_en     <= (state_q == StPlay);
      game_freeze <= (state_q != StPlay);
      state       <= state_q;
    end
  end

endmodule
